// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: RISC-V MemOP codes, FSM states,
// byte-enable constants and the access-fault / store-lane helpers.
package dmem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Misaligned H/W, reserved MemOP codes, and unsigned stores are all access faults.
  function automatic logic is_fault(input logic we, input logic [2:0] memop,
                                    input logic [1:0] addr_lo);
    logic f;
    case (memop)
      MEMOP_B:  f = 1'b0;
      MEMOP_BU: f = we;
      MEMOP_H:  f = addr_lo[0];
      MEMOP_HU: f = addr_lo[0] | we;
      MEMOP_W:  f = |addr_lo;
      default:  f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = BE_BYTE << addr_lo;
      2'b01:   be = BE_HALF << addr_lo;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  // Replicate the store data across lanes so the byte enables alone pick the target bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{data[7:0]}};
      2'b01:   lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data extraction: selects the addressed byte/half lane of a bus word and
// sign- or zero-extends it according to the RISC-V MemOP.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  memop,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // Halfword faults guarantee addr_lo[0]==0, so only addr_lo[1] picks the half.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (memop)
      MEMOP_B:  data = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_BU: data = {24'h0, byte_sel};
      MEMOP_H:  data = {{16{half_sel[15]}}, half_sel};
      MEMOP_HU: data = {16'h0, half_sel};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the single-cycle core's memory stage and a req/ack bus.
// Optional bus timeout abort is enabled by defining DMEM_TIMEOUT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_memop,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  state_t      state_q, state_d;
  logic        fault;
  logic        accept;
  logic [1:0]  addr_lo_q;
  logic [2:0]  memop_q;
  logic [31:0] load_data;
  logic        timeout_hit;
  logic        timeout_q;

  assign fault  = is_fault(cpu_we, cpu_memop, cpu_addr[1:0]);
  assign accept = (state_q == IDLE) && cpu_req && !fault;

  dmem_load_align u_load_align (
    .word    (bus_rdata),
    .addr_lo (addr_lo_q),
    .memop   (memop_q),
    .data    (load_data)
  );

`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;

  // The final waiting cycle aborts only if the ack has not arrived in that same cycle.
  assign timeout_hit = (state_q == REQ) && !bus_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (accept) begin
        cnt_q <= '0;
      end else if (state_q == REQ && !bus_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
  assign unused_cfg  = (TIMEOUT_CYCLES > CNT_W);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    cpu_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (fault) begin
            cpu_err = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        cpu_stall = 1'b1;
        if (bus_ack || timeout_hit) state_d = DONE;
      end
      DONE: begin
        cpu_err = timeout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req = (state_q == REQ);

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= BE_NONE;
      bus_wdata <= '0;
      addr_lo_q <= '0;
      memop_q   <= MEMOP_W;
    end else if (accept) begin
      bus_we    <= cpu_we;
      bus_addr  <= {cpu_addr[31:2], 2'b00};
      bus_be    <= cpu_we ? store_be(cpu_memop[1:0], cpu_addr[1:0]) : BE_WORD;
      bus_wdata <= cpu_we ? store_lanes(cpu_memop[1:0], cpu_wdata) : '0;
      addr_lo_q <= cpu_addr[1:0];
      memop_q   <= cpu_memop;
    end
  end

  // Load data is captured only on a completing load; stores and faults leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata <= '0;
    end else if (state_q == REQ && !bus_we) begin
      if (bus_ack)          cpu_rdata <= load_data;
      else if (timeout_hit) cpu_rdata <= '0;
    end
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the CPU's memory stage.
- Takes a load/store (address, write data, MemOP) from the single-cycle core and drives a word-wide req/ack memory bus.
- Stalls the core (`pc` hold) until the access completes, then returns the load data aligned and extended.
- Converts the byte/half/word RISC-V accesses into bus byte-enables and back.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for `bus_ack` before abort (used only with DMEM_TIMEOUT_EN).
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  level: memory access requested this instruction.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_memop  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- cpu_addr  in  32  byte address (ALU Result).
- cpu_wdata  in  32  store data (rs2).
- cpu_rdata  out  32  aligned/extended load data, registered.
- cpu_stall  out  1  hold PC/state this cycle.
- cpu_err  out  1  access fault this cycle.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address {cpu_addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word.
- bus_ack  in  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, outputs forced immediately.
  - `cpu_rdata`=0, `bus_req`=0, `bus_we`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0, timeout counter=0.
  - A reset mid-access drops `bus_req` immediately; any later `bus_ack` is ignored.
- Fault check (combinational on inputs, IDLE only):
  - Fault if: H/HU with addr[0]=1; W with addr[1:0]!=0; memop in {011,110,111}; store with memop BU/HU.
- IDLE:
  - `cpu_req`=1 and no fault: latch the access, go to REQ. `cpu_stall`=1 this cycle.
  - `cpu_req`=1 with fault: `cpu_err`=1 and `cpu_stall`=0 for that cycle. No bus access, store suppressed, `cpu_rdata` unchanged. Stay IDLE.
- REQ:
  - `bus_req`=1 and `cpu_stall`=1.
  - `bus_addr`, `bus_we`, `bus_be`, `bus_wdata` come from registered copies and stay stable until ack.
  - On `bus_ack`: for a load, register the extracted data into `cpu_rdata`. Go to DONE.
  - `bus_ack` in the same cycle `bus_req` first rises is legal (1-cycle bus).
- DONE:
  - `cpu_stall`=0 for exactly one cycle so the core retires the instruction.
  - `cpu_req` is ignored this cycle (same instruction). Next state is IDLE.
- Latency: a load/store with ack in the first REQ cycle stalls 2 cycles and completes in the 3rd.
- `bus_ack` outside REQ: ignored.
- Byte enables and store data:
  - B: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - H: be=0011<<addr[1:0], wdata={2{wdata[15:0]}}.
  - W: be=1111, wdata=wdata.
  - Loads assert be=1111.
- Load extract:
  - Select lane by addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W pass-through.
- `cpu_rdata` holds its value across stores and faults.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: drop `bus_req`, go to DONE, `cpu_err`=1 during that DONE cycle, `cpu_rdata` forced to 0 for loads.
  - An ack arriving on the timeout cycle wins (normal completion).
- When undefined: no counter logic; REQ waits indefinitely; `cpu_err` comes only from faults.

Decomposition:
- Package dmem_pkg:
  - MEMOP_B/H/W/BU/HU localparams.
  - State encoding IDLE/REQ/DONE (2-bit).
  - Byte-enable constants.
- Sub-module dmem_load_align: combinational lane select plus sign/zero extend (inputs: word, addr[1:0], memop). Reused by the bench as its reference model.

Test Plan:
- LB at 0x103, bus_rdata=0x80FF_1234, ack on the 1st REQ cycle -> bus_addr=0x100, be=1111, stall 2 cycles, cpu_rdata=0xFFFF_FF80.
- SH at 0x202, wdata=0xAAAA_BEEF, ack after 3 cycles -> bus_we=1, be=1100, bus_wdata=0xBEEF_BEEF, stable while bus_req=1, cpu_rdata unchanged.
- LHU at 0x201 (misaligned) and memop=011 -> cpu_err=1, cpu_stall=0, bus_req never rises, no state change.
- Back-to-back LW 0x0 then LW 0x4 (rdata 0x1111_1111, 0x2222_2222) -> DONE ignores cpu_req, second access starts the following IDLE, cpu_rdata sequence correct.
- rst pulled low while in REQ -> bus_req=0 immediately, state IDLE; a late bus_ack is ignored; next access is clean.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 REQ cycles, cpu_err=1 in DONE, cpu_rdata=0; repeat with ack on cycle 4 -> normal completion, no err.
